// File: rtl/shl_seq.sv
// ---------------------------------------------------------------------------
// shl_seq: multi-cycle left shifter / rotator.
//   One power-of-two barrel stage per clock; stage k shifts by 2^k when
//   shift-amount bit k is set. Every operation takes SH_W stages regardless
//   of the shift amount, so the result is ready a fixed SH_W cycles after
//   start is accepted.
// Ports:
//   clock  system clock, rising edge
//   clear  synchronous active-high reset, overrides everything
//   start  request, sampled only while idle
//   op     0 = SHL (zero fill), 1 = ROL
//   A      operand
//   B      shift amount (only B[SH_W-1:0] used)
//   busy   operation in progress
//   done   one-cycle completion pulse
//   Z      registered result, held until next completion
//   cout   SHL: last bit shifted out; ROL: Z[0]; 0 when shift amount is 0
// ---------------------------------------------------------------------------
module shl_seq #(
  parameter int SH_W       = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Z,
  output logic                  cout
);

  localparam int KW = (SH_W > 1) ? $clog2(SH_W) : 1;
  localparam logic [SH_W:0] DW_L   = (SH_W+1)'(DATA_WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(SH_W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [DATA_WIDTH-1:0] w_q;
  logic [SH_W-1:0] sh_q;
  logic [KW-1:0]   k_q;
  logic            op_q;
  logic            c_q;

  // Upper shift-amount bits are architecturally ignored.
  logic unused_b;
  assign unused_b = ^B[DATA_WIDTH-1:SH_W];

  // Current stage: amt = 2^k. hi holds the bits leaving the top of the word,
  // right-aligned, so hi[0] is the last bit shifted out and hi is also the
  // wrap-around field for ROL.
  logic [SH_W:0]         amt;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] w_d;
  logic                  c_d;

  always_comb begin
    amt = (SH_W+1)'(1) << k_q;
    hi  = w_q >> (DW_L - amt);
    w_d = w_q;
    c_d = c_q;
    if (sh_q[k_q]) begin
      w_d = (w_q << amt) | (op_q ? hi : '0);
      if (!op_q) c_d = hi[0];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      Z       <= '0;
      cout    <= 1'b0;
      w_q     <= '0;
      sh_q    <= '0;
      k_q     <= '0;
      op_q    <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            w_q     <= A;
            sh_q    <= B[SH_W-1:0];
            op_q    <= op;
            k_q     <= '0;
            c_q     <= 1'b0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          w_q <= w_d;
          c_q <= c_d;
          k_q <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            Z       <= w_d;
            // ROL with zero shift reports no carry even if bit 0 is set.
            cout    <= op_q ? ((sh_q != '0) & w_d[0]) : c_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            k_q     <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shl_seq.sv
module tb_shl_seq;

  logic        clock = 1'b0;
  logic        clear, start, op;
  logic [31:0] A, B;
  logic        busy, done, cout;
  logic [31:0] Z;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  shl_seq #(.SH_W(5), .DATA_WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .done(done), .Z(Z), .cout(cout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the architectural definition: {cout, Z}.
  function automatic logic [32:0] ref_op(input logic o, input logic [31:0] a, input logic [31:0] b);
    int          sh;
    logic [31:0] z;
    logic        c;
    sh = int'(b[4:0]);
    if (sh == 0) return {1'b0, a};
    if (!o) begin
      z = a << sh;
      c = a[32 - sh];
    end else begin
      z = (a << sh) | (a >> (32 - sh));
      c = z[0];
    end
    return {c, z};
  endfunction

  // Transaction-level model: accept when not busy, deliver after 5 edges.
  logic        m_busy = 0, m_done = 0, m_cout = 0;
  logic [31:0] m_Z = '0;
  logic [32:0] m_pend;
  int          m_rem = 0;

  always @(posedge clock) begin
    if (clear) begin
      m_busy = 0; m_done = 0; m_Z = '0; m_cout = 0; m_rem = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1; m_Z = m_pend[31:0]; m_cout = m_pend[32];
        end
      end else if (start) begin
        m_pend = ref_op(op, A, B);
        m_rem  = 5;
        m_busy = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("sb_busy", 32'(busy), 32'(m_busy));
      chk("sb_done", 32'(done), 32'(m_done));
      chk("sb_Z",    Z,         m_Z);
      chk("sb_cout", 32'(cout), 32'(m_cout));
    end
  end

  // Called away from a clock edge; returns 1 ns after the edge that raised done.
  task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] expz, input logic expc, input string nm,
                     input bit chk_hold, input logic [31:0] hold_z);
    int lat, bc;
    bit got;
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'h0000_0007; op = ~o;  // must not affect the run
    bc = busy ? 1 : 0;
    lat = 0; got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clock); #1;
      if (done) begin got = 1; lat = i; end
      else begin
        if (busy) bc++;
        if (chk_hold) chk({nm, "_hold"}, Z, hold_z);
      end
    end
    chk({nm, "_lat"},  32'(lat), 32'd5);
    chk({nm, "_busy"}, 32'(bc),  32'd5);
    chk({nm, "_Z"},    Z,        expz);
    chk({nm, "_cout"}, 32'(cout), 32'(expc));
  endtask

  initial begin
    int  nd;
    bit  got;
    clear = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;

    // Pin the model against hand-computed values.
    chk("model_shl31", ref_op(1'b0, 32'h1, 32'd31)[31:0], 32'h8000_0000);
    chk("model_rol4",  ref_op(1'b1, 32'h8000_0001, 32'hFFFF_FFE4)[31:0], 32'h0000_0018);
    chk("model_shl16c", 32'(ref_op(1'b0, 32'hFFFF_FFFF, 32'd16)[32]), 32'd1);

    repeat (3) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_Z",    Z,         32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk_en = 1'b1;

    @(negedge clock);
    run(1'b0, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, "shl31", 0, '0);
    @(negedge clock);
    run(1'b0, 32'h8000_0001, 32'd1, 32'h0000_0002, 1'b1, "shl1", 0, '0);
    @(negedge clock);
    run(1'b1, 32'h8000_0001, 32'd1, 32'h0000_0003, 1'b1, "rol1", 0, '0);
    @(negedge clock);
    run(1'b1, 32'h8000_0001, 32'hFFFF_FFE4, 32'h0000_0018, 1'b0, "rol4", 0, '0);
    @(negedge clock);
    run(1'b1, 32'h8000_0001, 32'd32, 32'h8000_0001, 1'b0, "rol0", 0, '0);
    @(negedge clock);
    run(1'b0, 32'h8000_0002, 32'd31, 32'h0000_0000, 1'b1, "shl31c", 0, '0);
    @(negedge clock);
    run(1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, "shl0", 0, '0);
    // back-to-back: start in the done cycle
    run(1'b0, 32'h0000_000F, 32'd8, 32'h0000_0F00, 1'b0, "b2b", 1, 32'h1234_5678);

    // Start while busy is ignored.
    @(negedge clock);
    op = 1'b0; A = 32'hFFFF_FFFF; B = 32'd16; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    A = '0; B = '0; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clock); #1;
      if (done) got = 1;
    end
    chk("ign_done", 32'(got), 32'd1);
    chk("ign_Z",    Z,        32'hFFFF_0000);
    chk("ign_cout", 32'(cout), 32'd1);
    repeat (8) @(posedge clock);
    #1 chk("ign_nostart", 32'(busy), 32'd0);

    // Clear during RUN aborts.
    @(negedge clock);
    op = 1'b0; A = 32'h0000_00F0; B = 32'd3; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) @(posedge clock);
    #1 clear = 1'b1;
    @(posedge clock); #1 clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_Z",    Z,         32'd0);
    chk("clr_cout", 32'(cout), 32'd0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (done) nd++;
    end
    chk("clr_nodone", 32'(nd), 32'd0);
    @(negedge clock);
    run(1'b0, 32'h0000_00F0, 32'd3, 32'h0000_0780, 1'b0, "post_clr", 0, '0);

    @(negedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
